// File: rtl/keypad_scan_sequencer.sv
// rtl/keypad_scan_sequencer.sv - 16-key matrix scanner driving a 4-to-16 decoder, with press/release debounce
module keypad_scan_sequencer #(
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic       sense_n,
  output logic [3:0] sel,
  output logic       sel_en_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready
);

  typedef enum logic [1:0] {SCAN, CONFIRM, REPORT, RELEASE} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE - 1);

  state_t     state, state_d;
  logic [7:0] dwell, dwell_d;
  logic [7:0] count, count_d;
  logic [3:0] sel_d, key_code_d;
  logic       key_valid_d, sel_en_n_d;
  logic       sync1, s_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SCAN;
      sel       <= 4'd0;
      sel_en_n  <= 1'b1;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      dwell     <= 8'd0;
      count     <= 8'd0;
      sync1     <= 1'b1;
      s_sync    <= 1'b1;
    end else begin
      state     <= state_d;
      sel       <= sel_d;
      sel_en_n  <= sel_en_n_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      dwell     <= dwell_d;
      count     <= count_d;
      sync1     <= sense_n;
      s_sync    <= sync1;
    end
  end

  always_comb begin
    state_d     = state;
    sel_d       = sel;
    dwell_d     = dwell;
    count_d     = count;
    key_code_d  = key_code;
    key_valid_d = key_valid;
    case (state)
      SCAN: begin
        // Pausing parks dwell at 0 so the resumed position gets a full settle time
        if (!scan_en) begin
          dwell_d = 8'd0;
        end else if (dwell == DWELL_LAST) begin
          dwell_d = 8'd0;
          if (s_sync) begin
            sel_d = sel + 4'd1;
          end else if (DEBOUNCE == 1) begin
            state_d     = REPORT;
            key_code_d  = sel;
            key_valid_d = 1'b1;
          end else begin
            state_d = CONFIRM;
            count_d = 8'd1;
          end
        end else begin
          dwell_d = dwell + 8'd1;
        end
      end
      CONFIRM: begin
        if (s_sync) begin
          state_d = SCAN;
          sel_d   = sel + 4'd1;
          dwell_d = 8'd0;
        end else begin
          count_d = count + 8'd1;
          if (count == DEB_LAST) begin
            state_d     = REPORT;
            key_code_d  = sel;
            key_valid_d = 1'b1;
          end
        end
      end
      REPORT: begin
        if (key_valid && key_ready) begin
          key_valid_d = 1'b0;
          state_d     = RELEASE;
          count_d     = 8'd0;
        end
      end
      RELEASE: begin
        // Any low sample restarts the release run so a bouncing key is not re-armed early
        if (s_sync) begin
          count_d = count + 8'd1;
          if (count == DEB_LAST) begin
            state_d = SCAN;
            sel_d   = sel + 4'd1;
            dwell_d = 8'd0;
          end
        end else begin
          count_d = 8'd0;
        end
      end
      default: state_d = SCAN;
    endcase
    sel_en_n_d = (state_d == SCAN) && !scan_en;
  end

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// tb/tb_keypad_scan_sequencer.sv - self-checking bench for keypad_scan_sequencer
module tb_keypad_scan_sequencer;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        key_ready = 1'b0;
  logic        sense_n;
  logic [3:0]  sel, key_code;
  logic        sel_en_n, key_valid;
  logic [15:0] pressed = 16'd0;
  logic        bounce_en = 1'b0;
  logic        bounce_val = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  // Key matrix: only the decoder-selected key can pull the shared return line low
  assign sense_n = bounce_en ? bounce_val : !(!sel_en_n && pressed[sel]);

  keypad_scan_sequencer #(.SETTLE(SETTLE), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .sense_n(sense_n),
    .sel(sel), .sel_en_n(sel_en_n), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: phases of scanning rather than the RTL's encoding
  localparam int HUNT = 0, VERIFY = 1, HOLD = 2, WAIT_UP = 3;
  int         phase, age, run;
  logic [3:0] m_sel, m_code;
  logic       m_valid, m_en_n, h1, h2, s;
  bit         live = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase = HUNT; age = 0; run = 0;
      m_sel = 4'd0; m_code = 4'd0; m_valid = 1'b0; m_en_n = 1'b1;
      h1 = 1'b1; h2 = 1'b1;
      live = 1;
    end else begin
      s = h2;
      case (phase)
        HUNT: begin
          if (!scan_en) age = 0;
          else if (age < SETTLE - 1) age++;
          else begin
            age = 0;
            if (s) m_sel = m_sel + 4'd1;
            else if (DEB == 1) begin phase = HOLD; m_valid = 1'b1; m_code = m_sel; end
            else begin phase = VERIFY; run = 1; end
          end
        end
        VERIFY: begin
          if (s) begin phase = HUNT; m_sel = m_sel + 4'd1; age = 0; end
          else begin
            run++;
            if (run == DEB) begin phase = HOLD; m_valid = 1'b1; m_code = m_sel; end
          end
        end
        HOLD: if (key_ready) begin m_valid = 1'b0; phase = WAIT_UP; run = 0; end
        default: begin
          if (s) begin
            run++;
            if (run == DEB) begin phase = HUNT; m_sel = m_sel + 4'd1; age = 0; end
          end else run = 0;
        end
      endcase
      m_en_n = (phase == HUNT) && !scan_en;
      h2 = h1;
      h1 = sense_n;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_sel", 32'(sel), 32'(m_sel));
      chk("model_sel_en_n", 32'(sel_en_n), 32'(m_en_n));
      chk("model_key_valid", 32'(key_valid), 32'(m_valid));
      chk("model_key_code", 32'(key_code), 32'(m_code));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sel(input logic [3:0] v, input int lim, input string name);
    int n = 0;
    while (sel !== v && n < lim) begin @(negedge clk); n++; end
    chk(name, 32'(sel), 32'(v));
  endtask

  task automatic wait_valid(input int lim, input string name, output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < lim) begin @(negedge clk); n++; end
    chk(name, 32'(key_valid), 32'd1);
  endtask

  initial begin
    int n;
    // 1. reset and free scan
    scan_en = 1'b1;
    tick(2);
    chk("t1_rst_sel", 32'(sel), 32'd0);
    chk("t1_rst_en_n", 32'(sel_en_n), 32'd1);
    chk("t1_rst_valid", 32'(key_valid), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("t1_en_n_low", 32'(sel_en_n), 32'd0);
    tick(3);
    chk("t1_step", 32'(sel), 32'd1);
    for (int i = 2; i <= 16; i++) begin
      tick(4);
      chk("t1_step", 32'(sel), 32'(i % 16));
    end

    // 2. single press at key 9
    pressed[9] = 1'b1;
    wait_sel(4'd9, 60, "t2_reach9");
    wait_valid(12, "t2_valid", n);
    chk("t2_latency_le9", 32'(n <= 9), 32'd1);
    chk("t2_code", 32'(key_code), 32'd9);
    chk("t2_model_code", 32'(m_code), 32'd9);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    chk("t2_ack", 32'(key_valid), 32'd0);
    tick(3);
    chk("t2_held_sel", 32'(sel), 32'd9);
    pressed[9] = 1'b0;
    tick(4);
    chk("t2_release_wait", 32'(sel), 32'd9);
    tick(1);
    chk("t2_resume10", 32'(sel), 32'd10);
    chk("t2_model_sel", 32'(m_sel), 32'd10);

    // 3. bounce at key 5, then a stable press
    wait_sel(4'd5, 80, "t3_reach5");
    bounce_en = 1'b1; bounce_val = 1'b1;
    tick(1); bounce_val = 1'b0;
    tick(1); bounce_val = 1'b1;
    tick(1); bounce_val = 1'b0;
    tick(1); bounce_val = 1'b1;
    tick(1); bounce_en = 1'b0;
    chk("t3_bounce_sel6", 32'(sel), 32'd6);
    chk("t3_bounce_novalid", 32'(key_valid), 32'd0);
    pressed[5] = 1'b1;
    wait_valid(100, "t3_valid", n);
    chk("t3_code", 32'(key_code), 32'd5);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    tick(10);
    chk("t3_once", 32'(key_valid), 32'd0);
    pressed[5] = 1'b0;
    wait_sel(4'd6, 20, "t3_resume6");

    // 4. backpressure at key 12
    pressed[12] = 1'b1;
    wait_valid(100, "t4_valid", n);
    chk("t4_code", 32'(key_code), 32'd12);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("t4_hold_valid", 32'(key_valid), 32'd1);
      chk("t4_hold_code", 32'(key_code), 32'd12);
      chk("t4_hold_sel", 32'(sel), 32'd12);
    end
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    pressed[12] = 1'b0;
    wait_sel(4'd13, 20, "t4_resume13");

    // 5. pause at 15, resume and wrap
    wait_sel(4'd15, 80, "t5_reach15");
    scan_en = 1'b0;
    tick(1);
    chk("t5_pause_en_n", 32'(sel_en_n), 32'd1);
    tick(9);
    chk("t5_frozen", 32'(sel), 32'd15);
    chk("t5_still_disabled", 32'(sel_en_n), 32'd1);
    scan_en = 1'b1;
    tick(3);
    chk("t5_dwell_restart", 32'(sel), 32'd15);
    chk("t5_en_n_low", 32'(sel_en_n), 32'd0);
    tick(1);
    chk("t5_wrap0", 32'(sel), 32'd0);

    // 6. reset while an event is pending
    pressed[3] = 1'b1;
    wait_valid(100, "t6_valid", n);
    chk("t6_code", 32'(key_code), 32'd3);
    rst_n = 1'b0;
    tick(1);
    chk("t6_rst_valid", 32'(key_valid), 32'd0);
    chk("t6_rst_sel", 32'(sel), 32'd0);
    chk("t6_rst_en_n", 32'(sel_en_n), 32'd1);
    pressed = 16'd0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk("t6_scan_resumed", 32'(sel), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
